hc165_reader: RTL

HC165_READER -- requirements
Module: hc165_reader

---
 rtl/hc165_pkg.sv | 17 +
 rtl/hc165_reader_if.sv | 28 ++
 rtl/hc165_tick.sv | 25 ++
 rtl/hc165_reader.sv | 115 +++++++++++
 4 files changed

// File: rtl/hc165_pkg.sv
// Shared types and constants for the 74HC165 chain reader.
package hc165_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_HI,
    SHIFT_LO,
    FINISH
  } state_t;

  localparam int DIV_W       = 8;
  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DIV_MAX = 255;

endpackage

// File: rtl/hc165_reader_if.sv
// Host and chain signals of the 74HC165 reader, grouped for port binding.
// Handshake: START is a one-cycle request taken only while the reader idles
// (BUSY low); BUSY then stays high through the cycle where DONE pulses with DATA valid.
interface hc165_reader_if #(
  parameter int NUM_CHIPS = 2
);
  localparam int N = 8 * NUM_CHIPS;

  logic         START;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] DATA;
  logic         PL_n;
  logic         CP;
  logic         CE_n;
  logic         Q7;

  modport master (
    output START, Q7,
    input  BUSY, DONE, DATA, PL_n, CP, CE_n
  );

  modport slave (
    input  START, Q7,
    output BUSY, DONE, DATA, PL_n, CP, CE_n
  );

endinterface

// File: rtl/hc165_tick.sv
// Phase timer: counts DIV cycles per phase, held at zero while restart is high.
module hc165_tick
  import hc165_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Wrapping on tc is the reload at every phase change.
  always_ff @(posedge clk) begin
    if (rst || restart || tc) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/hc165_reader.sv
// Reads a daisy chain of 74HC165 shift registers into a parallel frame.
// DATA[N-1] holds the first bit shifted out of the chain.
module hc165_reader
  import hc165_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int CLK_DIV   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  hc165_reader_if.slave  bus,
  output state_t         dbg_state
);

  localparam int N     = 8 * NUM_CHIPS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int DIV   = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN :
                         (CLK_DIV > CLK_DIV_MAX) ? CLK_DIV_MAX : CLK_DIV;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t           state;
  logic             pl_n;
  logic             cp;
  logic             ce_n;
  logic             busy;
  logic             done;
  logic [N-1:0]     data;
  logic [N-1:0]     shift_q;
  logic [N-1:0]     shift_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             restart;
  logic             tc;

  // The timer only runs inside the timed phases.
  assign restart = (state == IDLE) || (state == FINISH);

  hc165_tick #(.DIV(DIV)) u_tick (
    .clk     (CLK),
    .rst     (RST),
    .restart (restart),
    .tc      (tc)
  );

  assign shift_nxt = {shift_q[N-2:0], bus.Q7};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pl_n    <= 1'b1;
      cp      <= 1'b0;
      ce_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            state   <= LOAD;
            pl_n    <= 1'b0;
            ce_n    <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          if (tc) begin
            state <= SETTLE;
            pl_n  <= 1'b1;
          end
        end
        // Both phases end with a Q7 sample; the Nth sample closes the frame
        // and publishes the completed word together with DONE.
        SETTLE, SHIFT_LO: begin
          if (tc) begin
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= FINISH;
              data  <= shift_nxt;
              done  <= 1'b1;
              ce_n  <= 1'b1;
            end else begin
              state <= SHIFT_HI;
              cp    <= 1'b1;
            end
          end
        end
        SHIFT_HI: begin
          if (tc) begin
            state <= SHIFT_LO;
            cp    <= 1'b0;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.PL_n   = pl_n;
  assign bus.CP     = cp;
  assign bus.CE_n   = ce_n;
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.DATA   = data;
  assign dbg_state  = state;

endmodule
